seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It latches a packed hex value through a load strobe and applies it only at frame boundaries, so the display never tears. It cycles the digit anodes with a blanking guard between digits and feeds each selected nibble through one `seven_seg_decoder` instance. It sits between the system datapath (value producer) and the board display pins.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seven_seg_decoder.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   SEG_BLANK   - active-low pattern with every segment off
//   MAX_DIGITS  - largest digit count supported by the scanner
//   state_e     - scan FSM states (blanking guard / digit drive)
//   lz_mask()   - per-digit leading-zero blank mask for a packed hex value
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_e;

    // Bit i is set when nibbles num_digits-1 down to i are all zero.
    // Digit 0 always shows, so bit 0 is never set.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input int                      num_digits
    );
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                all_zero   = all_zero && (value[4*i +: 4] == 4'h0);
                lz_mask[i] = all_zero;
            end
        end
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   hex_i [3:0] : nibble to display (0..F)
//   seg_o [6:0] : segments {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module seven_seg_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode multi-digit display.
// A loaded value is staged and only copied into the displayed (shadow) copy at
// a frame boundary, so a frame never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS   - digits scanned (1..8)
//   CLK_DIV      - clock cycles per digit slot (> BLANK_CYCLES)
//   BLANK_CYCLES - all-anodes-off guard at the start of each slot (>= 1)
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   value        - packed nibbles, digit 0 in value[3:0] (rightmost)
//   load         - one-cycle strobe capturing value/dp_mask/lz_blank
//   dp_mask      - per-digit decimal point enable
//   lz_blank     - leading-zero blanking enable
//   seg          - active-low segments {g,f,e,d,c,b,a}
//   dp           - active-low decimal point
//   an           - active-low anode enables, at most one low
//   frame_done   - one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Staging (written by load) and shadow (displayed) copies
    logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic                    stg_lz_q, stg_lz_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                    sh_lz_q, sh_lz_d;

    // Output registers
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    slot_end;
    logic                    boundary;

    // Decoder / digit-select signals
    logic [4*MAX_DIGITS-1:0] sh_val_ext;
    logic [NUM_DIGITS-1:0]   lz_bits;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              nib;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [6:0]              dec_seg;

    // -------------------------------------------------------------------------
    // Next-state: slot counter, FSM, digit index
    // -------------------------------------------------------------------------
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (state_q == S_DRIVE) && (idx_q == IDX_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        state_d  = state_q;
        idx_d    = idx_q;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == CNT_BLANK_LAST) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (slot_end) begin
                    state_d = S_BLANK;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_BLANK;
        endcase
    end

    // -------------------------------------------------------------------------
    // Staging / pending / shadow update
    // -------------------------------------------------------------------------
    always_comb begin
        stg_val_d = stg_val_q;
        stg_dp_d  = stg_dp_q;
        stg_lz_d  = stg_lz_q;
        pend_d    = pend_q;
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        sh_lz_d   = sh_lz_q;
        // The shadow takes the staging contents as they were before this edge,
        // so a load coinciding with the boundary waits for the next frame.
        if (boundary && pend_q) begin
            sh_val_d = stg_val_q;
            sh_dp_d  = stg_dp_q;
            sh_lz_d  = stg_lz_q;
            pend_d   = 1'b0;
        end
        if (load) begin
            stg_val_d = value;
            stg_dp_d  = dp_mask;
            stg_lz_d  = lz_blank;
            pend_d    = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output next-values. Built from the next state so the registered outputs
    // change on the same edge as the state register.
    // -------------------------------------------------------------------------
    always_comb begin
        sh_val_ext                   = '0;
        sh_val_ext[4*NUM_DIGITS-1:0] = sh_val_d;
        lz_bits                      = NUM_DIGITS'(lz_mask(sh_val_ext, NUM_DIGITS));

        nib       = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib       = sh_val_d[4*i +: 4];
                sel_dp    = sh_dp_d[i];
                sel_blank = sh_lz_d && lz_bits[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    seven_seg_decoder u_dec (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        fd_d  = boundary;
        if (state_d == S_DRIVE) begin
            an_d  = an_sel;
            seg_d = sel_blank ? SEG_BLANK : dec_seg;
            dp_d  = ~sel_dp;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            stg_val_q <= '0;
            stg_dp_q  <= '0;
            stg_lz_q  <= 1'b0;
            pend_q    <= 1'b0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            sh_lz_q   <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stg_val_q <= stg_val_d;
            stg_dp_q  <= stg_dp_d;
            stg_lz_q  <= stg_lz_d;
            pend_q    <= pend_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            sh_lz_q   <= sh_lz_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Scoreboard bench: a time-based reference model pushes the expected output
// vector for every clock edge; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int CD    = 8;
    localparam int B     = 2;
    localparam int FRAME = N * CD;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fd;
    } exp_t;

    localparam exp_t RST_EXP = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*N-1:0] value = '0;
    logic           load = 1'b0;
    logic [N-1:0]   dp_mask = '0;
    logic           lz_blank = 1'b0;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   an;
    logic           frame_done;

    int n_cmp = 0;
    int n_err = 0;

    exp_t expq[$];

    // Model state
    int             mt = 0;
    logic [4*N-1:0] stg_v = '0, sh_v = '0;
    logic [N-1:0]   stg_m = '0, sh_m = '0;
    logic           stg_lz = 1'b0, sh_lz = 1'b0;
    logic           m_pend = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: run exceeded time limit, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected display t cycles after reset release, from slot arithmetic.
    function automatic exp_t expect_at(input int t, input logic [4*N-1:0] v,
                                       input logic [N-1:0] m, input logic lz);
        exp_t e;
        int   p, d, hi;
        p    = t % CD;
        d    = (t / CD) % N;
        e    = RST_EXP;
        e.fd = (t > 0) && (t % FRAME == 0);
        if (p >= B) begin
            hi = -1;
            for (int k = 0; k < N; k++) if (v[4*k +: 4] != 4'h0) hi = k;
            e.an = ~(N'(1) << d);
            e.dp = ~m[d];
            if (lz && d > hi && d > 0) e.seg = 7'h7F;
            else                       e.seg = dec7(v[4*d +: 4]);
        end
        return e;
    endfunction

    // Reference model: one expected vector per rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            mt = 0; stg_v = '0; stg_m = '0; stg_lz = 1'b0; m_pend = 1'b0;
            sh_v = '0; sh_m = '0; sh_lz = 1'b0;
            expq.push_back(RST_EXP);
        end else begin
            mt++;
            if (mt % FRAME == 0 && m_pend) begin
                sh_v = stg_v; sh_m = stg_m; sh_lz = stg_lz; m_pend = 1'b0;
            end
            if (load) begin
                stg_v = value; stg_m = dp_mask; stg_lz = lz_blank; m_pend = 1'b1;
            end
            expq.push_back(expect_at(mt, sh_v, sh_m, sh_lz));
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e, g;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g = {an, seg, dp, frame_done};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0d got an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                         mt, g.an, g.seg, g.dp, g.fd, e.an, e.seg, e.dp, e.fd);
            end
        end
        n_cmp++;
        if ($countones(~an) > 1) begin
            n_err++;
            $display("FAIL one_hot_anode t=%0d got an=%b required at most one low", mt, an);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge where the model
    // time sits at phase ph of the frame.
    task automatic goto_phase(input int ph);
        for (int i = 0; i < FRAME + 1 && (mt % FRAME) != ph; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] m, input logic lz);
        value = v; dp_mask = m; lz_blank = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        value = $urandom; dp_mask = N'($urandom); lz_blank = 1'($urandom);
    endtask

    function automatic logic [4*N-1:0] rand_val();
        logic [4*N-1:0] v;
        for (int k = 0; k < N; k++) v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return v;
    endfunction

    initial begin
        idle(3);
        rst_n = 1'b1;

        // Free-running scan with the reset (all-zero) shadow
        idle(2 * FRAME);

        // Mid-frame load, visible only after the boundary
        goto_phase(10);
        do_load(16'hA180, 4'b0000, 1'b0);
        idle(2 * FRAME);

        // Two loads in one frame: newest wins
        goto_phase(5);
        do_load(16'h1111, 4'b0001, 1'b0);
        goto_phase(20);
        do_load(16'h2222, 4'b1000, 1'b0);
        idle(2 * FRAME);

        // Load in the exact boundary cycle
        goto_phase(FRAME - 1);
        do_load(16'h3456, 4'b0101, 1'b0);
        idle(3 * FRAME);

        // Leading-zero blanking
        goto_phase(7);
        do_load(16'h0050, 4'b0100, 1'b1);
        idle(2 * FRAME);
        do_load(16'h0000, 4'b0000, 1'b1);
        idle(2 * FRAME);

        // Randomized loads at random phases
        for (int r = 0; r < 60; r++) begin
            idle($urandom_range(0, 40));
            do_load(rand_val(), N'($urandom), 1'($urandom));
        end
        idle(2 * FRAME);

        // Asynchronous reset during digit 2 drive with a load pending
        goto_phase(3);
        do_load(16'h9876, 4'b1111, 1'b0);
        goto_phase(2 * CD + B + 1);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({an, seg, dp, frame_done} !== RST_EXP) begin
            n_err++;
            $display("FAIL async_reset got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        idle(3);
        rst_n = 1'b1;
        idle(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
